// File: rtl/spi_sched.sv
// Round-robin scheduler sharing one SPI engine among NREQ requesters.
// It issues one word per grant and returns the read word to the owner, with a minimum idle gap and a stall timeout.
module spi_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned word_size = 16,
  parameter int unsigned min_gap   = 8,
  parameter int unsigned timeout   = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*word_size-1:0] req_data,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic [word_size-1:0]      rd_data,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clear,
  output logic                      spi_strobe_out,
  output logic [word_size-1:0]      spi_value_out,
  input  logic                      spi_strobe_in,
  input  logic [word_size-1:0]      spi_value_in
);

  localparam int unsigned OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TO_LAST  = 16'(timeout - 1);
  localparam logic [15:0] GAP_LOAD = 16'(min_gap);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } state_e;

  state_e                 state_q;
  logic [OW-1:0]          owner_q;
  logic [OW-1:0]          last_owner_q;
  logic [15:0]            cnt_q;
  logic                   edge_q;
  logic [NREQ-1:0]        grant_q;
  logic [NREQ-1:0]        done_q;
  logic [word_size-1:0]   rd_data_q;
  logic                   busy_q;
  logic                   timeout_err_q;
  logic                   strobe_q;
  logic [word_size-1:0]   value_q;

  logic                   strobe_rise;
  logic                   win_valid;
  logic [OW-1:0]          win_idx;
  logic [OW-1:0]          cand;

  always_comb begin
    strobe_rise = spi_strobe_in & ~edge_q;
  end

  // Search starts one past the previous owner and wraps, so each requester waits at most NREQ-1 words.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = OW'((32'(last_owner_q) + i) % NREQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_owner_q  <= OW'(NREQ - 1);
      cnt_q         <= '0;
      edge_q        <= 1'b0;
      grant_q       <= '0;
      done_q        <= '0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      strobe_q      <= 1'b0;
      value_q       <= '0;
    end else begin
      edge_q   <= spi_strobe_in;
      grant_q  <= '0;
      done_q   <= '0;
      strobe_q <= 1'b0;
      if (err_clear) begin
        timeout_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q      <= NREQ'(1) << win_idx;
            strobe_q     <= 1'b1;
            value_q      <= req_data[32'(win_idx)*word_size +: word_size];
            owner_q      <= win_idx;
            last_owner_q <= win_idx;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (strobe_rise) begin
            rd_data_q <= spi_value_in;
            done_q    <= NREQ'(1) << owner_q;
            cnt_q     <= GAP_LOAD;
            state_q   <= GAP;
          end else if (cnt_q == TO_LAST) begin
            // Later assignment overrides a simultaneous err_clear.
            timeout_err_q <= 1'b1;
            cnt_q         <= GAP_LOAD;
            state_q       <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q <= 16'd1) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign rd_data        = rd_data_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
  assign spi_strobe_out = strobe_q;
  assign spi_value_out  = value_q;

endmodule

// File: tb/tb_spi_sched.sv
// Directed bench for spi_sched: table of arbitration vectors plus hand-written
// sequences for timeout, stale strobe level, zero gap and mid-transaction reset.
module tb_spi_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, grant, done;
  logic [63:0] req_data;
  logic [15:0] rd_data, spi_vo, spi_vi;
  logic        busy, terr, err_clear, spi_so, spi_si;

  logic [3:0]  req2, grant2, done2;
  logic [15:0] rd_data2, spi_vo2, spi_vi2;
  logic        busy2, terr2, spi_so2, spi_si2;

  spi_sched #(.NREQ(4), .word_size(16), .min_gap(8), .timeout(16)) u_dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .rd_data(rd_data), .busy(busy),
    .timeout_err(terr), .err_clear(err_clear),
    .spi_strobe_out(spi_so), .spi_value_out(spi_vo),
    .spi_strobe_in(spi_si), .spi_value_in(spi_vi)
  );

  spi_sched #(.NREQ(4), .word_size(16), .min_gap(0), .timeout(16)) u_dut0 (
    .clock(clock), .reset(reset), .req(req2), .req_data(req_data),
    .grant(grant2), .done(done2), .rd_data(rd_data2), .busy(busy2),
    .timeout_err(terr2), .err_clear(1'b0),
    .spi_strobe_out(spi_so2), .spi_value_out(spi_vo2),
    .spi_strobe_in(spi_si2), .spi_value_in(spi_vi2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cyc = 0;

  typedef struct {
    logic [3:0]  req;
    int unsigned idx;
    logic [15:0] resp;
  } vec_t;

  vec_t        tbl [14];
  logic [15:0] words [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic wait_grant(output int waited, output bit ok);
    ok = 1'b0;
    waited = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (grant != 4'b0000) begin
        ok = 1'b1;
        waited = i;
        break;
      end
    end
    check("grant_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_txn(input logic [3:0] r, input int unsigned idx, input logic [15:0] resp,
                         input bit chk_gap, output int waited);
    bit ok;
    int gap;
    req = r;
    wait_grant(waited, ok);
    if (ok) begin
      gap = cyc - done_cyc;
      check("grant", 32'(grant), 32'(4'b0001 << idx));
      check("strobe_out", 32'(spi_so), 32'd1);
      check("value_out", 32'(spi_vo), 32'(words[idx]));
      check("busy", 32'(busy), 32'd1);
      if (chk_gap) begin
        n_tests++;
        if (gap < 9 || gap > 10) begin
          n_fail++;
          $display("FAIL gap8: got %0d clocks, expected 9..10", gap);
        end
      end
      @(negedge clock);
      check("grant_pulse", 32'(grant), 32'd0);
      check("strobe_pulse", 32'(spi_so), 32'd0);
      spi_vi = resp;
      spi_si = 1'b1;
      @(negedge clock);
      check("done", 32'(done), 32'(4'b0001 << idx));
      check("rd_data", 32'(rd_data), 32'(resp));
      done_cyc = cyc;
      spi_si = 1'b0;
      @(negedge clock);
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  w, n, d, gap2;
    bit  ok, seen_done, found;

    words[0] = 16'hA5C3;
    words[1] = 16'h1B1B;
    words[2] = 16'h2C2C;
    words[3] = 16'h3D3D;
    req_data = {words[3], words[2], words[1], words[0]};
    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 32'(i % 4), 16'(32'hC000 + i * 32'h0101)};
    tbl[8]  = '{4'b0001, 0, 16'h1234};
    tbl[9]  = '{4'b0110, 1, 16'hBEEF};
    tbl[10] = '{4'b1001, 3, 16'h0001};
    tbl[11] = '{4'b1001, 0, 16'hFFFF};
    tbl[12] = '{4'b0100, 2, 16'h8000};
    tbl[13] = '{4'b1010, 3, 16'h5555};

    reset = 1'b0; req = '0; spi_si = 1'b0; spi_vi = '0; err_clear = 1'b0;
    req2 = '0; spi_si2 = 1'b0; spi_vi2 = '0;
    repeat (3) @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobe", 32'(spi_so), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(terr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_value_out", 32'(spi_vo), 32'd0);
    reset = 1'b1;

    // Arbitration table: fairness rotation, single request, mixed masks.
    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].req, tbl[i].idx, tbl[i].resp, i > 0, w);
      if (i == 0) check("issue_latency", 32'(w), 32'd1);
    end

    // Timeout: engine never completes.
    req = 4'b0100;
    wait_grant(w, ok);
    check("to_grant", 32'(grant), 32'b0100);
    req = '0;
    n = 0;
    seen_done = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done != 4'b0000) seen_done = 1'b1;
      if (terr) begin
        n = i;
        break;
      end
    end
    check("timeout_cycles", 32'(n), 32'd16);
    check("timeout_no_done", 32'(seen_done), 32'd0);
    check("timeout_busy", 32'(busy), 32'd1);
    run_txn(4'b0001, 0, 16'h5A5A, 1'b0, w);
    req = '0;
    check("err_sticky", 32'(terr), 32'd1);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    check("err_clear", 32'(terr), 32'd0);

    // Stale completion level held across the next issue.
    req = 4'b0010;
    wait_grant(w, ok);
    check("stale_grant1", 32'(grant), 32'b0010);
    req = 4'b0100;
    @(negedge clock);
    spi_vi = 16'h7777;
    spi_si = 1'b1;
    @(negedge clock);
    check("stale_done1", 32'(done), 32'b0010);
    check("stale_rd1", 32'(rd_data), 32'h7777);
    wait_grant(w, ok);
    check("stale_grant2", 32'(grant), 32'b0100);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stale_no_done", 32'(done), 32'd0);
    end
    spi_si = 1'b0;
    @(negedge clock);
    check("stale_fall_no_done", 32'(done), 32'd0);
    spi_vi = 16'h8888;
    spi_si = 1'b1;
    @(negedge clock);
    check("stale_done2", 32'(done), 32'b0100);
    check("stale_rd2", 32'(rd_data), 32'h8888);
    spi_si = 1'b0;

    // Zero minimum gap on the second instance.
    req2 = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (spi_so2) begin
        found = 1'b1;
        break;
      end
    end
    check("gap0_first_issue", 32'(found), 32'd1);
    check("gap0_grant", 32'(grant2), 32'b0001);
    @(negedge clock);
    spi_vi2 = 16'h4242;
    spi_si2 = 1'b1;
    @(negedge clock);
    check("gap0_done", 32'(done2), 32'b0001);
    check("gap0_rd", 32'(rd_data2), 32'h4242);
    d = cyc;
    spi_si2 = 1'b0;
    gap2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (spi_so2) begin
        gap2 = cyc - d;
        break;
      end
    end
    check("gap0", 32'(gap2), 32'd2);
    req2 = '0;

    // Reset during WAIT_DONE.
    for (int i = 0; i < 30 && busy; i++) @(negedge clock);
    check("pre_reset_idle", 32'(busy), 32'd0);
    req = 4'b0100;
    wait_grant(w, ok);
    check("pre_reset_grant", 32'(grant), 32'b0100);
    req = '0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_strobe", 32'(spi_so), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(terr), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_value_out", 32'(spi_vo), 32'd0);
    @(negedge clock);
    check("mid_rst_hold_busy", 32'(busy), 32'd0);
    check("mid_rst_hold_done", 32'(done), 32'd0);
    reset = 1'b1;
    req = 4'b1111;
    @(negedge clock);
    check("post_rst_grant", 32'(grant), 32'b0001);
    check("post_rst_strobe", 32'(spi_so), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd1);
    req = '0;
    @(negedge clock);
    spi_vi = 16'h9999;
    spi_si = 1'b1;
    @(negedge clock);
    check("post_rst_done", 32'(done), 32'b0001);
    check("post_rst_rd", 32'(rd_data), 32'h9999);
    spi_si = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
